// File: rtl/sprite_ram_loader.sv
// Sprite pixel store: loads an SPR_W x SPR_H RGB565 image from a valid/ready stream, with a registered read port.
// Optional: define SPRITE_LOADER_ABORT_EN to add an abort input that cancels a load in progress.
module sprite_ram_loader #(
  parameter int SPR_W  = 20,
  parameter int SPR_H  = 20,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              busy,
  output logic              done,
  output logic              sprite_valid,
  input  logic [9:0]        x_offset,
  input  logic [9:0]        y_offset,
`ifdef SPRITE_LOADER_ABORT_EN
  input  logic              abort,
`endif
  output logic [DATA_W-1:0] pixel_data
);

  localparam int NPIX = SPR_W * SPR_H;
  localparam int AW   = $clog2(NPIX);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic              rd_in_range;
  logic              abort_hit;
  logic              we;
  logic              last_pix;
  logic [DATA_W-1:0] mem [NPIX];

  always_comb begin
    abort_hit = 1'b0;
`ifdef SPRITE_LOADER_ABORT_EN
    abort_hit = abort && (state == LOAD);
`endif
  end

  assign last_pix = (wr_addr == AW'(NPIX - 1));
  // Reset and abort both suppress the write of a pixel offered in the same cycle.
  assign we = (state == LOAD) && s_valid && s_ready && !abort_hit && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sprite_valid <= 1'b0;
      wr_addr      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            wr_addr      <= '0;
            sprite_valid <= 1'b0;
            s_ready      <= 1'b1;
            busy         <= 1'b1;
          end
        end
        LOAD: begin
          if (abort_hit) begin
            state   <= IDLE;
            wr_addr <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (s_valid) begin
            if (last_pix) begin
              state   <= DONE;
              wr_addr <= '0;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          sprite_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address computed at 32 bits; narrowing is safe because it is only used when in range.
  assign rd_addr     = AW'(32'(y_offset) * 32'(SPR_W) + 32'(x_offset));
  assign rd_in_range = (32'(x_offset) < SPR_W) && (32'(y_offset) < SPR_H);

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset)            pixel_data <= '0;
    else if (rd_in_range) pixel_data <= mem[rd_addr];
    else                  pixel_data <= '0;
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader: shadow RAM model plus read scoreboard.
module tb_sprite_ram_loader;

  logic        clk = 1'b0;
  logic        reset, start, s_valid, s_ready, busy, done, sprite_valid;
  logic [15:0] s_data, pixel_data;
  logic [9:0]  x_offset, y_offset;
`ifdef SPRITE_LOADER_ABORT_EN
  logic        abort;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] model [400];
  bit          known [400];
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  sprite_ram_loader #(.SPR_W(20), .SPR_H(20), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .busy(busy), .done(done), .sprite_valid(sprite_valid),
    .x_offset(x_offset), .y_offset(y_offset),
`ifdef SPRITE_LOADER_ABORT_EN
    .abort(abort),
`endif
    .pixel_data(pixel_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    reset = 1'b1; start = 1'b1; s_valid = 1'b0; s_data = '0;
    x_offset = '0; y_offset = '0;
`ifdef SPRITE_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sprite_valid !== 1'b0) begin errors++; $display("FAIL reset_sprite_valid got=%b exp=0", sprite_valid); end
    sb.push_back(16'h0000);
    e = sb.pop_front();
    checks++; if (pixel_data !== e) begin errors++; $display("FAIL reset_pixel_data got=%h exp=%h", pixel_data, e); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_wins_over_start busy=%b exp=0", busy); end
  endtask

  // Streams 400 pixels; each cycle also reads the address being written (read-first check).
  task automatic run_load(input bit toggle, input bit dmode, input int restart_at, input string tag);
    int idx, cyc, rdy;
    bit acc;
    logic [15:0] d, e;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL %s_enter_load s_ready=%b busy=%b exp=1,1", tag, s_ready, busy); end
    checks++; if (sprite_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_cleared got=%b exp=0", tag, sprite_valid); end
    idx = 0; cyc = 0; rdy = 0;
    while (idx < 400 && cyc < 2000) begin
      s_valid  = toggle ? ((cyc % 2) == 0) : 1'b1;
      d        = dmode ? 16'hF800 : 16'(idx);
      s_data   = d;
      start    = (idx == restart_at);
      x_offset = 10'(idx % 20);
      y_offset = 10'(idx / 20);
      if (known[idx]) sb.push_back(model[idx]);
      acc = s_valid && s_ready;
      if (s_ready) rdy++;
      if (acc) begin model[idx] = d; known[idx] = 1'b1; end
      tick();
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++; if (pixel_data !== e) begin errors++; $display("FAIL %s_read_first addr=%0d got=%h exp=%h", tag, idx, pixel_data, e); end
      end
      if (acc) idx++;
      cyc++;
      if (idx < 400 && done === 1'b1) begin checks++; errors++; $display("FAIL %s_early_done at idx=%0d got=1 exp=0", tag, idx); end
    end
    start = 1'b0; s_valid = 1'b0;
    checks++; if (idx != 400) begin errors++; $display("FAIL %s_timeout accepted=%0d exp=400", tag, idx); end
    checks++; if (cyc != (toggle ? 799 : 400)) begin errors++; $display("FAIL %s_cycles got=%0d exp=%0d", tag, cyc, toggle ? 799 : 400); end
    checks++; if (rdy != cyc) begin errors++; $display("FAIL %s_ready_cycles got=%0d exp=%0d", tag, rdy, cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done_pulse got=%b exp=1", tag, done); end
    checks++; if (s_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_exit_load s_ready=%b busy=%b exp=0,0", tag, s_ready, busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_one_cycle got=%b exp=0", tag, done); end
    checks++; if (sprite_valid !== 1'b1) begin errors++; $display("FAIL %s_sprite_valid got=%b exp=1", tag, sprite_valid); end
  endtask

  task automatic readback_all(input string tag);
    logic [15:0] e;
    for (int a = 0; a < 400; a++) begin
      x_offset = 10'(a % 20);
      y_offset = 10'(a / 20);
      sb.push_back(model[a]);
      tick();
      e = sb.pop_front();
      checks++; if (pixel_data !== e) begin errors++; $display("FAIL %s_readback addr=%0d got=%h exp=%h", tag, a, pixel_data, e); end
    end
  endtask

  task automatic test_full_load();
    logic [15:0] e;
    run_load(1'b0, 1'b0, -1, "full");
    x_offset = 10'd5; y_offset = 10'd3; sb.push_back(16'd65);
    tick(); e = sb.pop_front();
    checks++; if (pixel_data !== e) begin errors++; $display("FAIL read_5_3 got=%h exp=%h", pixel_data, e); end
    x_offset = 10'd19; y_offset = 10'd19; sb.push_back(16'd399);
    tick(); e = sb.pop_front();
    checks++; if (pixel_data !== e) begin errors++; $display("FAIL read_19_19 got=%h exp=%h", pixel_data, e); end
  endtask

  task automatic test_bounds();
    logic [15:0] e;
    int xs [4] = '{20, 0, 0, 1023};
    int ys [4] = '{0, 25, 1, 1023};
    logic [15:0] ex [4] = '{16'h0000, 16'h0000, 16'd20, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      x_offset = 10'(xs[i]); y_offset = 10'(ys[i]);
      sb.push_back(ex[i]);
      tick(); e = sb.pop_front();
      checks++; if (pixel_data !== e) begin errors++; $display("FAIL bounds x=%0d y=%0d got=%h exp=%h", xs[i], ys[i], pixel_data, e); end
    end
  endtask

  task automatic test_toggle_load();
    run_load(1'b1, 1'b0, -1, "toggle");
    readback_all("toggle");
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      s_valid = 1'b1; s_data = 16'h7000 + 16'(i);
      model[i] = s_data;
      tick();
    end
    s_data = 16'h5555;
    reset = 1'b1; tick(); reset = 1'b0; s_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (sprite_valid !== 1'b0) begin errors++; $display("FAIL midreset_sprite_valid got=%b exp=0", sprite_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midreset_s_ready got=%b exp=0", s_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_stays_idle busy=%b exp=0", busy); end
    run_load(1'b0, 1'b1, -1, "red");
    readback_all("red");
  endtask

  task automatic test_restart_ignored();
    run_load(1'b0, 1'b0, 200, "restart");
    readback_all("restart");
  endtask

`ifdef SPRITE_LOADER_ABORT_EN
  task automatic test_abort();
    logic [15:0] e;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = 16'h1000 + 16'(i);
      model[i] = s_data;
      tick();
    end
    s_valid = 1'b1; s_data = 16'hBEEF; abort = 1'b1;
    tick();
    abort = 1'b0; s_valid = 1'b0;
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b s_ready=%b exp=0,0", busy, s_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", done); end
    x_offset = 10'd0; y_offset = 10'd5; sb.push_back(model[100]);
    tick(); e = sb.pop_front();
    checks++; if (pixel_data !== e) begin errors++; $display("FAIL abort_pixel100 got=%h exp=%h", pixel_data, e); end
    checks++; if (sprite_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_after sprite_valid=%b done=%b exp=0,0", sprite_valid, done); end
    x_offset = 10'd19; y_offset = 10'd4; sb.push_back(model[99]);
    tick(); e = sb.pop_front();
    checks++; if (pixel_data !== e) begin errors++; $display("FAIL abort_pixel99 got=%h exp=%h", pixel_data, e); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 400; i++) begin model[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_full_load();
    test_bounds();
    test_toggle_load();
    test_reset_mid_load();
    test_restart_ignored();
`ifdef SPRITE_LOADER_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
